// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// peripheral source indices and the cause-width helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SERVICE,
        HOLDOFF
    } irq_state_t;

    localparam int SRC_TIMER   = 0;
    localparam int SRC_UART_RX = 1;
    localparam int SRC_UART_TX = 2;
    localparam int SRC_SWITCH  = 3;

    // A single source still needs a 1-bit cause field.
    function automatic int cause_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req, plus a valid
// flag that is high whenever any request bit is set.
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [CAUSE_W-1:0] idx,
    output logic               valid
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        idx   = '0;
        valid = |req;
        // Scanning downwards lets the lowest index overwrite any higher one.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detected pending bits, enable mask, priority
// select and a small FSM that issues one IRQ to IF only at a safe point.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = cause_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               en_wr,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               ack_wr,
    input  logic [NUM_SRC-1:0] ack_wdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic               eret,
    output logic               irq_out,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] enable,
    output logic               in_service
);

    irq_state_t         state;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] active;
    logic [CAUSE_W-1:0] top_idx;
    logic               any_active;
    logic               safe;

    // A rising edge sets pending even if software clears the same bit this cycle.
    assign rise         = src_irq & ~src_prev;
    assign clr_mask     = ack_wr ? ack_wdata : '0;
    assign pending_next = (pending & ~clr_mask) | rise;
    assign active       = pending & enable;

    // The return PC is only trustworthy when nothing in IF/ID is being redirected.
    assign safe = ~stall & ~flush & ~id_branch & ~id_jump;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio_enc (
        .req   (active),
        .idx   (top_idx),
        .valid (any_active)
    );

    assign irq_out    = (state == ARMED) && any_active && safe;
    assign in_service = (state == SERVICE);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src_prev  <= '0;
            pending   <= '0;
            enable    <= '0;
            irq_cause <= '0;
        end else begin
            src_prev <= src_irq;
            pending  <= pending_next;
            if (en_wr) begin
                enable <= en_wdata;
            end

            unique case (state)
                IDLE: begin
                    if (any_active) state <= ARMED;
                end
                ARMED: begin
                    if (!any_active) begin
                        state <= IDLE;
                    end else if (safe) begin
                        irq_cause <= top_idx;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eret) state <= HOLDOFF;
                end
                HOLDOFF: begin
                    state <= any_active ? ARMED : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations along each scenario.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int CAUSE_W = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_SRC-1:0] src_irq = '0;
    logic               en_wr = 1'b0;
    logic [NUM_SRC-1:0] en_wdata = '0;
    logic               ack_wr = 1'b0;
    logic [NUM_SRC-1:0] ack_wdata = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic               id_branch = 1'b0;
    logic               id_jump = 1'b0;
    logic               eret = 1'b0;
    logic               irq_out;
    logic [CAUSE_W-1:0] irq_cause;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic               in_service;

    irq_controller #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_irq    (src_irq),
        .en_wr      (en_wr),
        .en_wdata   (en_wdata),
        .ack_wr     (ack_wr),
        .ack_wdata  (ack_wdata),
        .stall      (stall),
        .flush      (flush),
        .id_branch  (id_branch),
        .id_jump    (id_jump),
        .eret       (eret),
        .irq_out    (irq_out),
        .irq_cause  (irq_cause),
        .pending    (pending),
        .enable     (enable),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a handler is either running (m_svc) or just returned (m_hold);
    // otherwise a request may go out only if something was active last cycle.
    logic [NUM_SRC-1:0] m_pending, m_enable, m_prev;
    logic [CAUSE_W-1:0] m_cause;
    bit                 m_svc, m_hold, m_prev_any;

    function automatic bit m_irq();
        logic [NUM_SRC-1:0] act;
        bit safe_now;
        act      = m_pending & m_enable;
        safe_now = !stall && !flush && !id_branch && !id_jump;
        return !m_svc && !m_hold && m_prev_any && (|act) && safe_now;
    endfunction

    function automatic logic [CAUSE_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) return CAUSE_W'(i);
        end
        return '0;
    endfunction

    always @(posedge clk or negedge reset) begin : model_update
        logic [NUM_SRC-1:0] act;
        bit fire;
        if (!reset) begin
            m_pending  = '0;
            m_enable   = '0;
            m_prev     = '0;
            m_cause    = '0;
            m_svc      = 1'b0;
            m_hold     = 1'b0;
            m_prev_any = 1'b0;
        end else begin
            act  = m_pending & m_enable;
            fire = m_irq();
            if (fire) begin
                m_cause = lowest(act);
                m_svc   = 1'b1;
                m_hold  = 1'b0;
            end else if (m_svc && eret) begin
                m_svc  = 1'b0;
                m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
            end
            m_prev_any = |act;
            m_pending  = (m_pending & ~(ack_wr ? ack_wdata : 4'b0000)) | (src_irq & ~m_prev);
            m_prev     = src_irq;
            if (en_wr) m_enable = en_wdata;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("model irq_out", irq_out, m_irq());
            check("model in_service", in_service, m_svc);
            check("model pending", pending, m_pending);
            check("model enable", enable, m_enable);
            if (m_svc) check("model irq_cause", irq_cause, m_cause);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #3;
        check("reset irq_out", irq_out, 0);
        check("reset irq_cause", irq_cause, 0);
        check("reset pending", pending, 0);
        check("reset enable", enable, 0);
        check("reset in_service", in_service, 0);
        #9;
        reset = 1'b1;

        // Single source on UART RX
        next_cycle(); en_wr = 1'b1; en_wdata = 4'b0010;
        next_cycle(); en_wr = 1'b0; src_irq[SRC_UART_RX] = 1'b1;
        sample(); check("t1 no irq at edge cycle", irq_out, 0);
        next_cycle(); src_irq = '0;
        sample(); check("t1 pending set", pending, 4'b0010);
        check("t1 no irq yet", irq_out, 0);
        next_cycle();
        sample(); check("t1 irq fires", irq_out, 1);
        next_cycle(); ack_wr = 1'b1; ack_wdata = 4'b0010;
        sample(); check("t1 irq single pulse", irq_out, 0);
        check("t1 in_service", in_service, 1);
        check("t1 cause", irq_cause, 1);
        next_cycle(); ack_wr = 1'b0; eret = 1'b1;
        sample(); check("t1 acked", pending, 0);
        next_cycle(); eret = 1'b0;
        sample(); check("t1 holdoff not in service", in_service, 0);
        next_cycle();
        sample(); check("t1 idle no irq", irq_out, 0);

        // Priority: UART RX beats SWITCH, then SWITCH after return
        next_cycle(); en_wr = 1'b1; en_wdata = 4'b1111; src_irq = 4'b1010;
        next_cycle(); en_wr = 1'b0;
        sample(); check("t2 pending", pending, 4'b1010);
        next_cycle();
        sample(); check("t2 irq", irq_out, 1);
        next_cycle(); ack_wr = 1'b1; ack_wdata = 4'b0010;
        sample(); check("t2 cause rx", irq_cause, 1);
        next_cycle(); ack_wr = 1'b0; eret = 1'b1; src_irq = '0;
        sample(); check("t2 pending after ack", pending, 4'b1000);
        next_cycle(); eret = 1'b0;
        sample(); check("t2 holdoff no irq", irq_out, 0);
        check("t2 holdoff not in service", in_service, 0);
        next_cycle();
        sample(); check("t2 reissue", irq_out, 1);
        next_cycle(); ack_wr = 1'b1; ack_wdata = 4'b1000;
        sample(); check("t2 cause switch", irq_cause, 3);
        next_cycle(); ack_wr = 1'b0; eret = 1'b1;
        next_cycle(); eret = 1'b0;
        next_cycle();
        sample(); check("t2 idle pending", pending, 0);

        // Unsafe window: 3 cycles of branch in ARMED, then one stall
        next_cycle(); src_irq[SRC_UART_TX] = 1'b1; id_branch = 1'b1;
        next_cycle();
        sample(); check("t3 idle", irq_out, 0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            sample(); check("t3 branch blocks", irq_out, 0);
        end
        next_cycle(); id_branch = 1'b0; stall = 1'b1;
        sample(); check("t3 stall blocks", irq_out, 0);
        next_cycle(); stall = 1'b0;
        sample(); check("t3 first safe cycle", irq_out, 1);
        next_cycle(); src_irq = '0; ack_wr = 1'b1; ack_wdata = 4'b0100;
        sample(); check("t3 cause tx", irq_cause, 2);

        // No nesting: timer request during the handler
        next_cycle(); ack_wr = 1'b0; src_irq[SRC_TIMER] = 1'b1;
        sample(); check("t4 no irq", irq_out, 0);
        next_cycle(); src_irq = '0;
        sample(); check("t4 pending timer", pending, 4'b0001);
        next_cycle();
        sample(); check("t4 still blocked", irq_out, 0);
        check("t4 still in service", in_service, 1);
        next_cycle(); eret = 1'b1;
        sample(); check("t4 eret cycle", irq_out, 0);
        next_cycle(); eret = 1'b0;
        sample(); check("t4 holdoff", irq_out, 0);
        next_cycle();
        sample(); check("t4 irq two after eret", irq_out, 1);
        next_cycle(); ack_wr = 1'b1; ack_wdata = 4'b0001;
        sample(); check("t4 cause timer", irq_cause, 0);
        next_cycle(); ack_wr = 1'b0; eret = 1'b1;
        next_cycle(); eret = 1'b0;
        next_cycle();
        sample(); check("t4 clean", pending, 0);

        // Ack/rise race on bit 2, then disable while ARMED
        next_cycle(); en_wr = 1'b1; en_wdata = 4'b1011; src_irq[SRC_UART_TX] = 1'b1;
        next_cycle(); en_wr = 1'b0; src_irq = '0;
        sample(); check("t5 masked pending", pending, 4'b0100);
        next_cycle(); src_irq[SRC_UART_TX] = 1'b1; ack_wr = 1'b1; ack_wdata = 4'b0100;
        next_cycle(); ack_wr = 1'b0; stall = 1'b1; en_wr = 1'b1; en_wdata = 4'b1111;
        sample(); check("t5 set wins over ack", pending, 4'b0100);
        next_cycle(); en_wr = 1'b0;
        sample(); check("t5 idle", irq_out, 0);
        next_cycle(); en_wr = 1'b1; en_wdata = 4'b1011;
        sample(); check("t5 armed but stalled", irq_out, 0);
        next_cycle(); en_wr = 1'b0; stall = 1'b0;
        sample(); check("t5 masked no irq", irq_out, 0);
        next_cycle();
        sample(); check("t5 back to idle", irq_out, 0);
        check("t5 not in service", in_service, 0);
        next_cycle(); src_irq = '0; ack_wr = 1'b1; ack_wdata = 4'b0100;
        next_cycle(); ack_wr = 1'b0;

        // Async reset mid-service
        next_cycle(); en_wr = 1'b1; en_wdata = 4'b1000; src_irq = 4'b1000;
        next_cycle(); en_wr = 1'b0; src_irq = 4'b0001;
        next_cycle();
        sample(); check("t6 irq", irq_out, 1);
        next_cycle();
        sample(); check("t6 in service", in_service, 1);
        check("t6 cause", irq_cause, 3);
        next_cycle();
        #2; reset = 1'b0;
        #1;
        check("t6 async irq_out", irq_out, 0);
        check("t6 async irq_cause", irq_cause, 0);
        check("t6 async pending", pending, 0);
        check("t6 async enable", enable, 0);
        check("t6 async in_service", in_service, 0);
        next_cycle(); #1; reset = 1'b1;
        sample(); check("t6 no replay", pending, 0);
        next_cycle();
        sample(); check("t6 held source seen as edge", pending, 4'b0001);
        next_cycle(); src_irq = '0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
